// File: rtl/mod_addsub_seq.sv
// Modular add/subtract sequencer: drives one shared multi-precision adder through
// two passes (a op b, then correction by m) and selects the in-range result.
module mod_addsub_seq #(
    parameter int W = 1027
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         op_sub,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_m,
    output logic [W-1:0] result,
    output logic         done,
    output logic         busy,
    output logic         add_start,
    output logic         add_subtract,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W:0]   add_result,
    input  logic         add_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P1_REQ  = 3'd1,
        P1_WAIT = 3'd2,
        P2_REQ  = 3'd3,
        P2_WAIT = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   m_q, m_d;
    logic           sub_q, sub_d;
    logic [W-1:0]   t_q, t_d;
    logic           neg1_q, neg1_d;
    logic [W-1:0]   res_q, res_d;
    logic [W-1:0]   add_a_q, add_a_d;
    logic [W-1:0]   add_b_q, add_b_d;
    logic           add_sub_q, add_sub_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            m_q       <= '0;
            sub_q     <= 1'b0;
            t_q       <= '0;
            neg1_q    <= 1'b0;
            res_q     <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_sub_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            sub_q     <= sub_d;
            t_q       <= t_d;
            neg1_q    <= neg1_d;
            res_q     <= res_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_sub_q <= add_sub_d;
        end
    end

    // Adder operands are registers loaded one edge ahead of each request state,
    // so they are stable for the whole start..done window of each pass.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        sub_d     = sub_q;
        t_d       = t_q;
        neg1_d    = neg1_q;
        res_d     = res_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_sub_d = add_sub_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d       = in_m;
                    sub_d     = op_sub;
                    add_a_d   = in_a;
                    add_b_d   = in_b;
                    add_sub_d = op_sub;
                    state_d   = P1_REQ;
                end
            end
            P1_REQ:  state_d = P1_WAIT;
            P1_WAIT: begin
                if (add_done) begin
                    t_d       = add_result[W-1:0];
                    neg1_d    = add_result[W];
                    add_a_d   = add_result[W-1:0];
                    add_b_d   = m_q;
                    add_sub_d = ~sub_q;
                    state_d   = P2_REQ;
                end
            end
            P2_REQ:  state_d = P2_WAIT;
            P2_WAIT: begin
                if (add_done) begin
                    // add: keep t unless t-m did not borrow; sub: use t+m only on borrow
                    if (sub_q)
                        res_d = neg1_q ? add_result[W-1:0] : t_q;
                    else
                        res_d = add_result[W] ? t_q : add_result[W-1:0];
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign add_start    = (state_q == P1_REQ) || (state_q == P2_REQ);
    assign add_subtract = add_sub_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign result       = res_q;
    assign done         = (state_q == FIN);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mod_addsub_seq.sv
// Bench for mod_addsub_seq at W=16 with a behavioural adder of programmable latency.
module tb_mod_addsub_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
    logic [W-1:0] result;
    logic         done, busy, add_start, add_subtract;
    logic [W-1:0] add_a, add_b;
    logic [W:0]   add_result;
    logic         add_done;
    logic         mdl_done = 1'b0;
    logic         stray_done = 1'b0;
    logic [W:0]   mdl_res = '0;

    int ncmp = 0, nfail = 0;
    int lat = 2;
    int pend = 0;
    int nstart = 0;
    bit viol = 1'b0;
    logic [W-1:0] sa, sb;
    logic ss;

    mod_addsub_seq #(.W(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op_sub(op_sub),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .result(result), .done(done), .busy(busy),
        .add_start(add_start), .add_subtract(add_subtract),
        .add_a(add_a), .add_b(add_b),
        .add_result(add_result), .add_done(add_done)
    );

    always #5 clk = ~clk;

    assign add_done   = mdl_done | stray_done;
    assign add_result = mdl_res;

    // Behavioural adder: answers lat edges after it samples add_start and checks
    // that the requester holds operands and does not re-start meanwhile.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend     = 0;
            mdl_done <= 1'b0;
        end else begin
            mdl_done <= 1'b0;
            if (pend > 0 && (add_a !== sa || add_b !== sb || add_subtract !== ss || add_start))
                viol = 1'b1;
            if (add_start && pend == 0) begin
                nstart++;
                sa = add_a; sb = add_b; ss = add_subtract;
                pend = lat;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mdl_done <= 1'b1;
                    mdl_res  <= ss ? ({1'b0, sa} - {1'b0, sb}) : ({1'b0, sa} + {1'b0, sb});
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_mod(input bit sub, input int a, input int b, input int m);
        if (sub) return (a - b + m) % m;
        return (a + b) % m;
    endfunction

    // One operation; latency counts edges after the start-sampling edge, so done
    // appears after 2D+2 further edges (edge 2D+3 counting the start edge as 1).
    task automatic run_op(input string tag, input bit sub, input int a, input int b,
                          input int m, input int d, input bit repulse, input bit stray);
        int n, n0;
        lat = d;
        @(negedge clk);
        op_sub = sub; in_a = W'(a); in_b = W'(b); in_m = W'(m);
        start = 1'b1; stray_done = stray;
        n0 = nstart;
        @(posedge clk); #1;
        start = 1'b0; stray_done = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (repulse && n == 2) begin
                start = 1'b1; op_sub = ~sub; in_a = 16'd1; in_b = 16'd2; in_m = 16'd5;
            end else if (repulse && n == 3) begin
                start = 1'b0;
            end
        end
        chk({tag, ".latency"}, 64'(n), 64'(2 * d + 2));
        chk({tag, ".result"}, 64'(result), 64'(ref_mod(sub, a, b, m)));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'd1);
        chk({tag, ".add_starts"}, 64'(nstart - n0), 64'd2);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".busy_after"}, 64'(busy), 64'd0);
        chk({tag, ".protocol"}, 64'(viol), 64'd0);
    endtask

    initial begin
        int n, n0, m, a, b;
        bit saw_done;
        #12;
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.add_start", 64'(add_start), 64'd0);
        chk("rst.add_sub", 64'(add_subtract), 64'd0);
        chk("rst.add_a", 64'(add_a), 64'd0);
        chk("rst.add_b", 64'(add_b), 64'd0);
        @(negedge clk); resetn = 1'b1;

        run_op("add50_60", 1'b0, 50, 60, 97, 2, 1'b0, 1'b0);
        run_op("add10_20", 1'b0, 10, 20, 97, 2, 1'b0, 1'b0);
        run_op("add_eq_m", 1'b0, 40, 57, 97, 2, 1'b0, 1'b0);
        run_op("sub10_20", 1'b1, 10, 20, 97, 2, 1'b0, 1'b0);
        run_op("sub20_10", 1'b1, 20, 10, 97, 2, 1'b0, 1'b0);
        run_op("sub33_33", 1'b1, 33, 33, 97, 2, 1'b0, 1'b0);
        run_op("repulse", 1'b0, 50, 60, 97, 2, 1'b1, 1'b0);
        run_op("stray_idle", 1'b1, 5, 90, 97, 2, 1'b0, 1'b1);
        run_op("lat_d1", 1'b0, 70, 80, 97, 1, 1'b0, 1'b0);
        run_op("lat_d2", 1'b1, 3, 96, 97, 2, 1'b0, 1'b0);
        run_op("lat_d5", 1'b0, 96, 1, 97, 5, 1'b0, 1'b0);

        // Stray add_done alone in IDLE must not start anything.
        @(negedge clk); stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        chk("stray.busy", 64'(busy), 64'd0);

        for (int i = 0; i < 20; i++) begin
            m = $urandom_range(32767, 2);
            a = $urandom_range(m - 1, 0);
            b = $urandom_range(m - 1, 0);
            run_op("rand", 1'($urandom_range(1, 0)), a, b, m, $urandom_range(4, 1), 1'b0, 1'b0);
        end

        // Reset while waiting on the second pass.
        lat = 3;
        @(negedge clk);
        op_sub = 1'b0; in_a = 16'd30; in_b = 16'd40; in_m = 16'd97; start = 1'b1;
        n0 = nstart;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (nstart - n0 < 2 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("midrst.reached_p2", 64'(nstart - n0), 64'd2);
        resetn = 1'b0;
        #1;
        chk("midrst.busy", 64'(busy), 64'd0);
        chk("midrst.done", 64'(done), 64'd0);
        chk("midrst.result", 64'(result), 64'd0);
        chk("midrst.add_a", 64'(add_a), 64'd0);
        chk("midrst.add_b", 64'(add_b), 64'd0);
        chk("midrst.add_sub", 64'(add_subtract), 64'd0);
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk); resetn = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("midrst.no_done", 64'(saw_done), 64'd0);
        chk("midrst.idle", 64'(busy), 64'd0);

        run_op("post_rst", 1'b0, 96, 96, 97, 2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
